// File: rtl/alu_pkg.sv
// Shared ALU definitions: op codes from the ALU controller, MULT/DIV engine states and width.
package alu_pkg;

    localparam int unsigned ALU_W = 32;

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_XOR   = 4'd1,
        OP_OR    = 4'd2,
        OP_AND   = 4'd3,
        OP_NOR   = 4'd4,
        OP_SLL   = 4'd5,
        OP_SRL   = 4'd6,
        OP_SLT   = 4'd7,
        OP_ADDU  = 4'd8,
        OP_ADD   = 4'd9,
        OP_SUB   = 4'd10,
        OP_SUBU  = 4'd11,
        OP_MULT  = 4'd12,
        OP_DIV   = 4'd13,
        OP_RSV14 = 4'd14,
        OP_RSV15 = 4'd15
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        FIX  = 2'd3
    } md_state_e;

    // True for the ops handled by the iterative engine
    function automatic logic is_md_op(input alu_op_e op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/mul_div_unit.sv
// Iterative signed MULT (shift-add) / DIV (restoring) engine owning the HI/LO registers.
module mul_div_unit
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             launch,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero,
    output logic             busy,
    output logic             finish_c
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    md_state_e         state, state_next;
    logic [CNT_W-1:0]  cnt;
    logic [WIDTH-1:0]  acc, quo, opnd, a_keep;
    logic              op_div, neg_q, neg_r, b_zero;

    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     mul_sum, div_shift, div_diff;
    logic [2*WIDTH-1:0] prod, prod_signed;

    assign mag_a = a[WIDTH-1] ? -a : a;
    assign mag_b = b[WIDTH-1] ? -b : b;

    // One shift-add / restoring-subtract step on the working registers
    assign mul_sum   = {1'b0, acc} + (quo[0] ? {1'b0, opnd} : '0);
    assign div_shift = {acc, quo[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, opnd};

    assign prod        = {acc, quo};
    assign prod_signed = neg_q ? -prod : prod;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        finish_c   = 1'b0;
        case (state)
            IDLE: if (launch) state_next = is_div ? DIV : MUL;
            MUL,
            DIV:  if (cnt == LAST_STEP) state_next = FIX;
            FIX: begin
                state_next = IDLE;
                finish_c   = 1'b1;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            acc         <= '0;
            quo         <= '0;
            opnd        <= '0;
            a_keep      <= '0;
            op_div      <= 1'b0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            b_zero      <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            div_by_zero <= 1'b0;
            busy        <= 1'b0;
        end else begin
            case (state)
                IDLE: if (launch) begin
                    cnt    <= '0;
                    busy   <= 1'b1;
                    acc    <= '0;
                    quo    <= is_div ? mag_a : mag_b;
                    opnd   <= is_div ? mag_b : mag_a;
                    a_keep <= a;
                    op_div <= is_div;
                    neg_q  <= a[WIDTH-1] ^ b[WIDTH-1];
                    neg_r  <= a[WIDTH-1];
                    b_zero <= (b == '0);
                end
                MUL: begin
                    acc <= mul_sum[WIDTH:1];
                    quo <= {mul_sum[0], quo[WIDTH-1:1]};
                    cnt <= cnt + CNT_W'(1);
                end
                DIV: begin
                    if (div_shift >= {1'b0, opnd}) begin
                        acc <= div_diff[WIDTH-1:0];
                        quo <= {quo[WIDTH-2:0], 1'b1};
                    end else begin
                        acc <= div_shift[WIDTH-1:0];
                        quo <= {quo[WIDTH-2:0], 1'b0};
                    end
                    cnt <= cnt + CNT_W'(1);
                end
                FIX: begin
                    busy <= 1'b0;
                    cnt  <= '0;
                    if (!op_div) begin
                        {hi, lo} <= prod_signed;
                    end else if (b_zero) begin
                        lo          <= '1;
                        hi          <= a_keep;
                        div_by_zero <= 1'b1;
                    end else begin
                        lo          <= neg_q ? -quo : quo;
                        hi          <= neg_r ? -acc : acc;
                        div_by_zero <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/multicycle_alu.sv
// Execute-stage ALU: single-cycle logic/shift/compare/add datapath plus the MULT/DIV handshake.
module multicycle_alu
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       alu_operation,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             zero,
    output logic             overflow,
    output logic             div_by_zero,
    output logic             busy,
    output logic             done
);

    alu_op_e          op;
    logic             accept, is_md, single, launch, finish_c;
    logic [WIDTH-1:0] sum, diff, sc_result;
    logic             sc_ovf;

    assign op     = alu_op_e'(alu_operation);
    assign accept = start && !busy;
    assign is_md  = is_md_op(op);
    assign single = accept && !is_md;
    assign launch = accept && is_md;
    assign sum    = a + b;
    assign diff   = a - b;

    always_comb begin
        sc_result = '0;
        sc_ovf    = 1'b0;
        case (op)
            OP_XOR:  sc_result = a ^ b;
            OP_OR:   sc_result = a | b;
            OP_AND:  sc_result = a & b;
            OP_NOR:  sc_result = ~(a | b);
            OP_SLL:  sc_result = b << a[4:0];
            OP_SRL:  sc_result = b >> a[4:0];
            OP_SLT:  sc_result = ($signed(a) < $signed(b)) ? WIDTH'(1) : '0;
            OP_ADDU: sc_result = sum;
            OP_SUBU: sc_result = diff;
            OP_ADD: begin
                sc_result = sum;
                sc_ovf    = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                sc_result = diff;
                sc_ovf    = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            default: sc_result = '0;
        endcase
    end

    // Single-cycle results and flags; MULT/DIV leave these untouched
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result   <= '0;
            zero     <= 1'b0;
            overflow <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= single || finish_c;
            if (single) begin
                result   <= sc_result;
                zero     <= (sc_result == '0);
                overflow <= sc_ovf;
            end
        end
    end

    mul_div_unit #(.WIDTH(WIDTH)) u_mul_div (
        .clk         (clk),
        .rst_n       (rst_n),
        .launch      (launch),
        .is_div      (op == OP_DIV),
        .a           (a),
        .b           (b),
        .hi          (hi),
        .lo          (lo),
        .div_by_zero (div_by_zero),
        .busy        (busy),
        .finish_c    (finish_c)
    );

endmodule

// File: tb/tb_multicycle_alu.sv
// Directed self-checking bench for multicycle_alu with hand-computed expectations.
module tb_multicycle_alu;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [3:0]  alu_operation;
    logic [31:0] a, b;
    logic [31:0] result, hi, lo;
    logic        zero, overflow, div_by_zero, busy, done;

    int total = 0;
    int bad   = 0;

    multicycle_alu dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .alu_operation (alu_operation),
        .a             (a),
        .b             (b),
        .result        (result),
        .hi            (hi),
        .lo            (lo),
        .zero          (zero),
        .overflow      (overflow),
        .div_by_zero   (div_by_zero),
        .busy          (busy),
        .done          (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Present a request for exactly one accept edge, then sample #1 after it
    task automatic issue(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        start         = 1'b1;
        alu_operation = op;
        a             = x;
        b             = y;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic single(input string tag, input logic [3:0] op, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] exp_res,
                          input logic exp_zero, input logic exp_ovf);
        issue(op, x, y);
        check({tag, "_res"}, 64'(result), 64'(exp_res));
        check({tag, "_zero"}, 64'(zero), 64'(exp_zero));
        check({tag, "_ovf"}, 64'(overflow), 64'(exp_ovf));
        check({tag, "_done"}, 64'(done), 64'd1);
        check({tag, "_busy"}, 64'(busy), 64'd0);
    endtask

    // Counts edges from the accept edge (as 1) up to the sample where done is seen
    task automatic wait_done(output int lat, output int busy_cyc);
        lat      = 1;
        busy_cyc = 0;
        while (!done && lat < 40) begin
            if (busy) busy_cyc++;
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic md(input string tag, input logic [3:0] op, input logic [31:0] x,
                      input logic [31:0] y, input logic [31:0] exp_hi,
                      input logic [31:0] exp_lo, input logic exp_dbz,
                      input logic [31:0] exp_res);
        int lat, bc;
        issue(op, x, y);
        wait_done(lat, bc);
        check({tag, "_lat"}, 64'(lat), 64'd34);
        check({tag, "_busycyc"}, 64'(bc), 64'd33);
        check({tag, "_hi"}, 64'(hi), 64'(exp_hi));
        check({tag, "_lo"}, 64'(lo), 64'(exp_lo));
        check({tag, "_dbz"}, 64'(div_by_zero), 64'(exp_dbz));
        check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
        check({tag, "_res_kept"}, 64'(result), 64'(exp_res));
        @(posedge clk);
        #1;
        check({tag, "_done_once"}, 64'(done), 64'd0);
    endtask

    initial begin
        int lat, bc;
        logic seen;
        rst_n         = 1'b0;
        start         = 1'b0;
        alu_operation = 4'd0;
        a             = '0;
        b             = '0;
        #12;
        check("rst_result", 64'(result), 64'd0);
        check("rst_hilo", {hi, lo}, 64'd0);
        check("rst_flags", 64'({zero, overflow, div_by_zero, busy, done}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        single("add_ovf",  4'd9,  32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        check("add_done_drop", 64'(done), 64'd0);
        single("addu",     4'd8,  32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b0, 1'b0);
        single("sub_zero", 4'd10, 32'd5, 32'd5, 32'h0, 1'b1, 1'b0);
        single("sub_ovf",  4'd10, 32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 1'b0, 1'b1);
        single("subu",     4'd11, 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b0, 1'b0);
        single("slt",      4'd7,  32'hFFFF_FFFF, 32'h1, 32'h1, 1'b0, 1'b0);
        single("slt_no",   4'd7,  32'h1, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0);
        single("srl",      4'd6,  32'd31, 32'h8000_0000, 32'h1, 1'b0, 1'b0);
        single("sll",      4'd5,  32'd4, 32'h0000_00F1, 32'h0000_0F10, 1'b0, 1'b0);
        single("nor",      4'd4,  32'h0F0F_0000, 32'h00F0_00FF, 32'hF000_FF00, 1'b0, 1'b0);
        single("or",       4'd2,  32'h1200_0000, 32'h0000_0034, 32'h1200_0034, 1'b0, 1'b0);
        single("op14",     4'd14, 32'h1234, 32'h5678, 32'h0, 1'b1, 1'b0);
        single("xor",      4'd1,  32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_FF00, 1'b0, 1'b0);

        md("mult_neg",  4'd12, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 32'hFF00);
        md("div_neg",   4'd13, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 32'hFF00);
        md("div_zero",  4'd13, 32'd9, 32'd0, 32'd9, 32'hFFFF_FFFF, 1'b1, 32'hFF00);
        md("mult_keep", 4'd12, 32'd5, 32'd6, 32'd0, 32'd30, 1'b1, 32'hFF00);
        md("div_min",   4'd13, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, 32'hFF00);

        // AND while busy is dropped; AND in the done cycle is taken
        issue(4'd13, 32'd100, 32'd7);
        repeat (4) @(posedge clk);
        issue(4'd3, 32'hF0, 32'h3C);
        check("ign_busy", 64'(busy), 64'd1);
        check("ign_done", 64'(done), 64'd0);
        wait_done(lat, bc);
        check("ign_seen", 64'(done), 64'd1);
        check("ign_hi", 64'(hi), 64'd2);
        check("ign_lo", 64'(lo), 64'd14);
        check("ign_res", 64'(result), 64'hFF00);
        issue(4'd3, 32'hF0, 32'h3C);
        check("and_res", 64'(result), 64'h30);
        check("and_done", 64'(done), 64'd1);

        // Reset in the middle of a MULT
        issue(4'd12, 32'd3, 32'd4);
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mrst_result", 64'(result), 64'd0);
        check("mrst_hilo", {hi, lo}, 64'd0);
        check("mrst_flags", 64'({zero, overflow, div_by_zero, busy, done}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        single("post_rst_add", 4'd9, 32'd2, 32'd3, 32'd5, 1'b0, 1'b0);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done || busy) seen = 1'b1;
        end
        check("no_stale_op", 64'(seen), 64'd0);
        check("no_stale_hilo", {hi, lo}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
